demux_1x8_sync: RTL and testbench

- Registered 1-to-8 demultiplexer. Routes data input i to the one output lane picked by the 3-bit select {s2,s1,s0}; all other lanes are driven to zero.
- Built as a combinational tree: one 1x2 stage on s2, feeding two 1x4 stages on {s1,s0}. An output register follows the tree.
- Used as a generic lane-steering leaf in datapath fabrics.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_1x2.sv | 26 ++
 rtl/demux_1x4.sv | 36 +++
 rtl/demux_1x8_sync.sv | 94 +++++++++
 tb/tb_demux_1x8_sync.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// demux_pkg
// Shared constants and helpers for the 1-to-8 lane demultiplexer.
//   N_OUT     : number of output lanes
//   SEL_W     : width of the lane select
//   lane_mask : one-hot lane mask for a given select value
package demux_pkg;

    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    // One-hot lane mask: bit k is set when sel == k.
    function automatic logic [N_OUT-1:0] lane_mask(input logic [SEL_W-1:0] sel);
        logic [N_OUT-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_1x2.sv
// demux_1x2
// Combinational 1-to-2 demultiplexer stage.
//   i  : data in
//   s  : select (0 -> y0, 1 -> y1)
//   y0 : lane 0, zero when not selected
//   y1 : lane 1, zero when not selected
module demux_1x2
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] i,
    input  logic              s,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1
);

    logic [1:0] mask;

    // Low two bits of the shared mask decode a 1-bit select.
    assign mask = 2'(lane_mask({2'b00, s}));

    assign y0 = mask[0] ? i : '0;
    assign y1 = mask[1] ? i : '0;

endmodule

// File: rtl/demux_1x4.sv
// demux_1x4
// Combinational 1-to-4 demultiplexer stage.
//   i      : data in
//   s1, s0 : select, s0 is the LSB
//   y0..y3 : lanes, only the selected one carries i
module demux_1x4
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] i,
    input  logic              s1,
    input  logic              s0,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3
);

    logic [3:0]        mask;
    logic [DATA_W-1:0] lanes [4];

    assign mask = 4'(lane_mask({1'b0, s1, s0}));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = mask[gi] ? i : '0;
        end
    endgenerate

    assign y0 = lanes[0];
    assign y1 = lanes[1];
    assign y2 = lanes[2];
    assign y3 = lanes[3];

endmodule

// File: rtl/demux_1x8_sync.sv
// demux_1x8_sync
// Registered 1-to-8 demultiplexer built as a 1x2 stage on s2 feeding two
// 1x4 stages on {s1,s0}, followed by an output register.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, clears y (and sel_q)
//   en         : register update enable, hold when low
//   i          : data to steer
//   s2, s1, s0 : lane select, s0 is the LSB
//   y          : 8 lanes, lane k = y[k*DATA_W +: DATA_W]
//   sel_q      : captured select, present only with DEMUX_1X8_SEL_OUT_EN
module demux_1x8_sync
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DATA_W-1:0]         i,
    input  logic                      s0,
    input  logic                      s1,
    input  logic                      s2,
    output logic [N_OUT*DATA_W-1:0]   y
`ifdef DEMUX_1X8_SEL_OUT_EN
    ,
    output logic [SEL_W-1:0]          sel_q
`endif
);

    logic [DATA_W-1:0]       lo_data;
    logic [DATA_W-1:0]       hi_data;
    logic [DATA_W-1:0]       lane [N_OUT];
    logic [N_OUT*DATA_W-1:0] y_next;
    logic [N_OUT*DATA_W-1:0] y_reg;

    // MSB picks the half, then each half decodes {s1,s0}.
    demux_1x2 #(.DATA_W(DATA_W)) u_stage_s2 (
        .i  (i),
        .s  (s2),
        .y0 (lo_data),
        .y1 (hi_data)
    );

    demux_1x4 #(.DATA_W(DATA_W)) u_stage_lo (
        .i  (lo_data),
        .s1 (s1),
        .s0 (s0),
        .y0 (lane[0]),
        .y1 (lane[1]),
        .y2 (lane[2]),
        .y3 (lane[3])
    );

    demux_1x4 #(.DATA_W(DATA_W)) u_stage_hi (
        .i  (hi_data),
        .s1 (s1),
        .s0 (s0),
        .y0 (lane[4]),
        .y1 (lane[5]),
        .y2 (lane[6]),
        .y3 (lane[7])
    );

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pack
            assign y_next[gi*DATA_W +: DATA_W] = lane[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg <= '0;
        end else if (en) begin
            y_reg <= y_next;
        end
    end

    assign y = y_reg;

`ifdef DEMUX_1X8_SEL_OUT_EN
    logic [SEL_W-1:0] sel_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg <= '0;
        end else if (en) begin
            sel_reg <= {s2, s1, s0};
        end
    end

    assign sel_q = sel_reg;
`endif

endmodule

// File: tb/tb_demux_1x8_sync.sv
// tb_demux_1x8_sync
// Drives a 1-bit-lane and a 4-bit-lane instance of demux_1x8_sync with the
// same clock, reset, enable and select, and checks both against a simple
// shift-based model of the expected lane pattern.
module tb_demux_1x8_sync;
    import demux_pkg::*;

    localparam int W1 = 1;
    localparam int W4 = 4;

    logic            clk;
    logic            rst;
    logic            en;
    logic [W1-1:0]   i1;
    logic [W4-1:0]   i4;
    logic [2:0]      sel;
    logic [8*W1-1:0] y1;
    logic [8*W4-1:0] y4;
`ifdef DEMUX_1X8_SEL_OUT_EN
    logic [2:0]      sel_q1;
    logic [2:0]      sel_q4;
`endif

    logic [8*W1-1:0] exp_y1;
    logic [8*W4-1:0] exp_y4;
    logic [2:0]      exp_sel;

    int assertions;
    int failures;

    demux_1x8_sync #(.DATA_W(W1)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i     (i1),
        .s0    (sel[0]),
        .s1    (sel[1]),
        .s2    (sel[2]),
        .y     (y1)
`ifdef DEMUX_1X8_SEL_OUT_EN
        ,
        .sel_q (sel_q1)
`endif
    );

    demux_1x8_sync #(.DATA_W(W4)) u_dut_w (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i     (i4),
        .s0    (sel[0]),
        .s1    (sel[1]),
        .s2    (sel[2]),
        .y     (y4)
`ifdef DEMUX_1X8_SEL_OUT_EN
        ,
        .sel_q (sel_q4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; the model follows the inputs present at that edge.
    // Outputs are then sampled 1 time unit later.
    task automatic edge_step();
        logic            en_s;
        logic [W1-1:0]   i1_s;
        logic [W4-1:0]   i4_s;
        logic [2:0]      sel_s;
        en_s  = en;
        i1_s  = i1;
        i4_s  = i4;
        sel_s = sel;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_y1  = '0;
            exp_y4  = '0;
            exp_sel = '0;
        end else if (en_s) begin
            exp_y1  = (8*W1)'(i1_s) << (int'(sel_s) * W1);
            exp_y4  = (8*W4)'(i4_s) << (int'(sel_s) * W4);
            exp_sel = sel_s;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; i1 = 1'b1; i4 = 4'hF; sel = 3'd5;
        exp_y1 = '0; exp_y4 = '0; exp_sel = '0;
        edge_step();
        edge_step();
        rst = 1'b0;
        edge_step();
        assertions++;
        if (y1 !== 8'h20) begin
            failures++;
            $display("FAIL reset_pre_capture: y=%h expected 20", y1);
        end
        // Asynchronous assertion between edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_y1 = '0; exp_y4 = '0; exp_sel = '0;
        assertions++;
        if (y1 !== 8'h00 || y4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: y1=%h y4=%h expected 0", y1, y4);
        end
        for (int k = 0; k < 3; k++) begin
            edge_step();
            assertions++;
            if (y1 !== 8'h00 || y4 !== 32'h0) begin
                failures++;
                $display("FAIL reset_hold%0d: y1=%h y4=%h expected 0", k, y1, y4);
            end
        end
`ifdef DEMUX_1X8_SEL_OUT_EN
        assertions++;
        if (sel_q1 !== 3'd0 || sel_q4 !== 3'd0) begin
            failures++;
            $display("FAIL reset_sel_q: sel_q=%0d/%0d expected 0", sel_q1, sel_q4);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        $display("reset: y1=%h y4=%h", y1, y4);
    endtask

    task automatic test_walk_selects();
        logic [7:0] walk_exp;
        en = 1'b1; i1 = 1'b1; i4 = 4'h9;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            edge_step();
            walk_exp = 8'h01 << s;
            assertions++;
            if (y1 !== walk_exp || y4 !== exp_y4) begin
                failures++;
                $display("FAIL walk_sel%0d: y1=%h y4=%h expected %h %h",
                         s, y1, y4, walk_exp, exp_y4);
            end
            $display("walk sel=%0d y1=%h y4=%h", s, y1, y4);
        end
    endtask

    task automatic test_data_zero();
        en = 1'b1; i1 = 1'b0; i4 = 4'h0; sel = 3'd3;
        edge_step();
        assertions++;
        if (y1 !== 8'h00 || y4 !== 32'h0) begin
            failures++;
            $display("FAIL data_zero: y1=%h y4=%h expected 0", y1, y4);
        end
        i1 = 1'b1;
        edge_step();
        assertions++;
        if (y1 !== 8'h08) begin
            failures++;
            $display("FAIL data_one_sel3: y=%h expected 08", y1);
        end
        $display("data_zero: y1=%h", y1);
    endtask

    task automatic test_enable_hold();
        en = 1'b1; i1 = 1'b1; sel = 3'd2;
        edge_step();
        en = 1'b0; sel = 3'd7; i1 = 1'b1; i4 = 4'h3;
        edge_step();
        edge_step();
        assertions++;
        if (y1 !== 8'h04 || y4 !== exp_y4) begin
            failures++;
            $display("FAIL enable_hold: y1=%h y4=%h expected 04 %h", y1, y4, exp_y4);
        end
        en = 1'b1;
        edge_step();
        assertions++;
        if (y1 !== 8'h80 || y4 !== 32'h3000_0000) begin
            failures++;
            $display("FAIL enable_resume: y1=%h y4=%h expected 80 30000000", y1, y4);
        end
        $display("enable_hold: y1=%h y4=%h", y1, y4);
    endtask

    task automatic test_mid_reset();
        en = 1'b1; i1 = 1'b1; sel = 3'd6;
        edge_step();
        assertions++;
        if (y1 !== 8'h40) begin
            failures++;
            $display("FAIL mid_reset_setup: y=%h expected 40", y1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        assertions++;
        if (y1 !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_async: y=%h expected 00", y1);
        end
        #2;
        rst = 1'b0;
        exp_y1 = '0; exp_y4 = '0; exp_sel = '0;
        #1;
        assertions++;
        if (y1 !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_release: y=%h expected 00", y1);
        end
        edge_step();
        assertions++;
        if (y1 !== 8'h40) begin
            failures++;
            $display("FAIL mid_reset_recapture: y=%h expected 40", y1);
        end
        $display("mid_reset: y1=%h", y1);
    endtask

    task automatic test_wide();
        en = 1'b1; i1 = 1'b0; i4 = 4'hA; sel = 3'd2;
        edge_step();
        assertions++;
        if (y4 !== 32'h0000_0A00) begin
            failures++;
            $display("FAIL wide_data: y=%h expected 00000a00", y4);
        end
`ifdef DEMUX_1X8_SEL_OUT_EN
        assertions++;
        if (sel_q4 !== 3'd2 || sel_q1 !== 3'd2) begin
            failures++;
            $display("FAIL wide_sel_q: sel_q=%0d/%0d expected 2", sel_q4, sel_q1);
        end
`endif
        $display("wide: y4=%h", y4);
    endtask

    task automatic test_random();
        int nz;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) != 0);
            i1  = W1'($urandom);
            i4  = W4'($urandom);
            sel = 3'($urandom);
            edge_step();
            nz = 0;
            for (int k = 0; k < N_OUT; k++) begin
                if (y4[k*W4 +: W4] != '0) nz++;
            end
            assertions++;
            if (y1 !== exp_y1 || y4 !== exp_y4 || nz > 1) begin
                failures++;
                $display("FAIL random%0d: y1=%h y4=%h lanes=%0d expected %h %h",
                         n, y1, y4, nz, exp_y1, exp_y4);
            end
`ifdef DEMUX_1X8_SEL_OUT_EN
            assertions++;
            if (sel_q4 !== exp_sel) begin
                failures++;
                $display("FAIL random_sel_q%0d: sel_q=%0d expected %0d", n, sel_q4, exp_sel);
            end
`endif
            $display("random %0d en=%0b sel=%0d i4=%h y4=%h", n, en, sel, i4, y4);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        rst = 1'b0; en = 1'b0; i1 = '0; i4 = '0; sel = '0;
        #2;
        test_reset();
        test_walk_selects();
        test_data_zero();
        test_enable_hold();
        test_mid_reset();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
